// File: rtl/rs232_rx_if.sv
// rs232_rx_if: byte stream from the UART receiver to its consumer.
//   out      received byte in [7:0], [31:8] always zero
//   out_stb  out is valid
//   out_ack  consumer accepts out
interface rs232_rx_if;
    logic [31:0] out;
    logic        out_stb;
    logic        out_ack;
    modport master (output out, output out_stb, input out_ack);
    modport slave (input out, input out_stb, output out_ack);
endinterface

// File: rtl/rs232_receiver.sv
// rs232_receiver: 8N1 LSB-first UART receiver presenting bytes on a stb/ack stream.
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   rx             serial line, idle high, asynchronous to clk
//   stream         out / out_stb / out_ack byte stream (master side)
//   framing_error  one-cycle pulse when the stop bit samples low
//   overrun        one-cycle pulse when a byte is dropped because out is still held
module rs232_receiver #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    rs232_rx_if.master stream,
    output logic       framing_error,
    output logic       overrun
);
    localparam int CPB = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW = $clog2(CPB);
    localparam logic [CW-1:0] RELOAD = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

    generate
        if (CPB < 4) begin : g_cpb_check
            $error("rs232_receiver: CLOCK_FREQUENCY/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          stb_q, stb_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;
    logic          rx_s;
    logic          tick;

    assign rx_s = sync_q[1];
    assign tick = cnt_q == '0;
    assign stream.out = {24'b0, data_q};
    assign stream.out_stb = stb_q;
    assign framing_error = fe_q;
    assign overrun = ov_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        shift_d = shift_q;
        data_d = data_q;
        stb_d = stb_q && !stream.out_ack;
        fe_d = 1'b0;
        ov_d = 1'b0;
        // The bit timer only runs while a frame is in flight.
        if (state_q != IDLE && state_q != BRK)
            cnt_d = tick ? RELOAD : cnt_q - 1'b1;
        case (state_q)
            IDLE: begin
                // Half a bit period lands the first sample mid start bit.
                if (!rx_s) begin
                    state_d = START;
                    cnt_d = HALF;
                end
            end
            START: begin
                if (tick) begin
                    state_d = rx_s ? IDLE : DATA;
                    idx_d = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d[idx_q] = rx_s;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7)
                        state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = rx_s ? IDLE : BRK;
                    fe_d = !rx_s;
                    // A byte may load in the same cycle the previous one is acked.
                    if (rx_s && (!stb_q || stream.out_ack)) begin
                        data_d = shift_q;
                        stb_d = 1'b1;
                    end
                    ov_d = rx_s && stb_q && !stream.out_ack;
                end
            end
            BRK: begin
                // A held-low line must not be mistaken for a stream of start bits.
                if (rx_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            state_q <= IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            shift_q <= '0;
            data_q <= '0;
            stb_q <= 1'b0;
            fe_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            shift_q <= shift_d;
            data_q <= data_d;
            stb_q <= stb_d;
            fe_q <= fe_d;
            ov_q <= ov_d;
        end
    end
endmodule

// File: tb/tb_rs232_receiver.sv
// tb_rs232_receiver: scoreboard bench for rs232_receiver at 16 clocks per bit.
//   Stimulus threads serialise frames and push the bytes the line should yield;
//   a monitor thread pops and compares on every accepted handshake and counts
//   error pulses against the expected totals.
module tb_rs232_receiver;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx = 1'b1;
    logic framing_error;
    logic overrun;
    rs232_rx_if stream();

    rs232_receiver #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .stream(stream),
        .framing_error(framing_error),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int stb_cyc = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    int ack_mode = 1;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic bit_out(logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic frame(logic [7:0] b, logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
    endtask

    task automatic idle(int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(name, exp_q.size(), 0);
        check({name, "_fe"}, fe_cnt, exp_fe);
        check({name, "_ov"}, ov_cnt, exp_ov);
    endtask

    initial begin
        stream.out_ack = 1'b1;
        fork
            forever begin
                @(negedge clk);
                stream.out_ack = ack_mode == 2 ? ($urandom_range(0, 3) == 0) : ack_mode[0];
            end
            begin : monitor
                logic [31:0] held;
                bit holding;
                holding = 1'b0;
                held = '0;
                forever begin
                    @(negedge clk);
                    #1;
                    if (framing_error) fe_cnt++;
                    if (overrun) ov_cnt++;
                    if (stream.out_stb) stb_cyc++;
                    if (stream.out_stb && holding) check("hold_stable", stream.out, held);
                    holding = stream.out_stb && !stream.out_ack;
                    held = stream.out;
                    if (stream.out_stb && stream.out_ack) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_byte: got %h want none", stream.out);
                        end else begin
                            check("byte", stream.out, {24'b0, exp_q.pop_front()});
                        end
                    end
                end
            end
        join_none

        repeat (4) @(negedge clk);
        #1;
        check("rst_out", stream.out, 0);
        check("rst_stb", stream.out_stb, 0);
        check("rst_fe", framing_error, 0);
        check("rst_ov", overrun, 0);
        rst = 1'b1;
        idle(5);

        // Single good frame, consumer always ready.
        stb_cyc = 0;
        exp_q.push_back(8'hA5);
        frame(8'hA5, 1'b1);
        idle(20);
        drain("t1");
        check("t1_stb_cycles", stb_cyc, 1);

        // Short low glitch must be rejected.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        drain("t2");

        // Bad stop bit followed by a long low line: one error, nothing else.
        frame(8'h3C, 1'b0);
        exp_fe++;
        repeat (200) @(negedge clk);
        idle(20);
        drain("t3");

        // Consumer stalled: second byte is dropped with an overrun pulse.
        ack_mode = 0;
        exp_q.push_back(8'h11);
        frame(8'h11, 1'b1);
        frame(8'h22, 1'b1);
        exp_ov++;
        idle(20);
        #1;
        check("t4_out_held", stream.out, 32'h11);
        check("t4_stb_held", stream.out_stb, 1);
        check("t4_ov", ov_cnt, exp_ov);
        ack_mode = 1;
        drain("t4");

        // Reset in the middle of data bit 4 abandons the byte.
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) bit_out(((8'h77 >> i) & 8'h01) != 0);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t5_rst_out", stream.out, 0);
        check("t5_rst_stb", stream.out_stb, 0);
        rst = 1'b1;
        idle(10);
        exp_q.push_back(8'h5A);
        frame(8'h5A, 1'b1);
        idle(20);
        drain("t5");

        // Back-to-back frames.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h81);
        frame(8'h00, 1'b1);
        frame(8'hFF, 1'b1);
        frame(8'h81, 1'b1);
        idle(20);
        drain("t6");

        // Random bytes, random bad stop bits, random consumer stalls.
        ack_mode = 2;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic good;
            b = 8'($urandom);
            good = $urandom_range(0, 4) != 0;
            if (good) exp_q.push_back(b);
            else exp_fe++;
            frame(b, good);
            if (!good) repeat ($urandom_range(0, 40)) @(negedge clk);
            idle($urandom_range(4, 30));
        end
        idle(20);
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
